muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit.
//   muldiv_op_t    : funct3 encoding of the M-extension operations
//   muldiv_state_t : control FSM states of muldiv_unit
//   op_a_signed / op_b_signed : operand signedness per operation
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_a_signed(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// A single 2*XLEN shift register and one XLEN+1 adder/subtractor serve both
// shift-add multiply and restoring divide on operand magnitudes; signs are
// restored in FIX. Divide-by-zero and signed overflow bypass the datapath.
//   clk, rst (sync, active-high), flush (abandon in-flight op)
//   in_valid/in_ready, in_op (funct3), in_a, in_b, in_tag : request
//   out_valid/out_ready, out_result, out_tag              : response
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | XLEN shift-add / restoring-divide iterations
// FIX   | apply result sign, select high/low half or quotient/remainder
// DONE  | result held on out_* until out_ready
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_t     r_state;
  muldiv_op_t        r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [TAG_W-1:0]  r_tag;
  logic              r_neg;
  logic [2*XLEN-1:0] r_shreg;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;

  // Returns {hit, result}: hit when the op completes without iterating.
  function automatic logic [XLEN:0] special_case(input muldiv_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic is_div;
    logic is_rem;
    logic is_signed;
    logic [XLEN:0] res;
    is_div    = op[2];
    is_rem    = op[1];
    is_signed = ~op[0];
    res       = '0;
    if (is_div && (b == '0)) begin
      res = {1'b1, (is_rem ? a : {XLEN{1'b1}})};
    end else if (is_div && is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (b == {XLEN{1'b1}})) begin
      res = {1'b1, (is_rem ? {XLEN{1'b0}} : a)};
    end
    return res;
  endfunction

  muldiv_op_t        w_op;
  logic [XLEN:0]     w_special;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg_res;
  logic              w_div;
  logic [XLEN:0]     w_add_a;
  logic [XLEN:0]     w_add_b;
  logic [XLEN:0]     w_sum;
  logic              w_ge;
  logic [2*XLEN-1:0] w_shreg_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dval;
  logic [XLEN-1:0]   w_dfix;
  logic [XLEN-1:0]   w_fix_res;

  always_comb begin
    w_op      = muldiv_op_t'(in_op);
    w_special = special_case(w_op, in_a, in_b);
    w_a_neg   = op_a_signed(w_op) & in_a[XLEN-1];
    w_b_neg   = op_b_signed(w_op) & in_b[XLEN-1];
    // The most-negative value negates to itself, which is its correct magnitude unsigned.
    w_a_mag   = w_a_neg ? (~in_a + XLEN'(1)) : in_a;
    w_b_mag   = w_b_neg ? (~in_b + XLEN'(1)) : in_b;
    // Remainder takes the dividend's sign; products and quotients the XOR.
    w_neg_res = (w_op[2] && w_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  // Shared adder: multiply adds the multiplicand into the high half when the
  // current multiplier bit is set; divide trial-subtracts the divisor from the
  // left-shifted partial remainder (XLEN+1 bits so the borrow is visible).
  always_comb begin
    w_div   = r_op[2];
    w_add_a = w_div ? r_shreg[2*XLEN-1:XLEN-1] : {1'b0, r_shreg[2*XLEN-1:XLEN]};
    if (w_div) begin
      w_add_b = ~{1'b0, r_b};
    end else begin
      w_add_b = r_shreg[0] ? {1'b0, r_b} : '0;
    end
    w_sum = w_add_a + w_add_b + {{XLEN{1'b0}}, w_div};
    w_ge  = ~w_sum[XLEN];
    if (w_div) begin
      w_shreg_next = {(w_ge ? w_sum[XLEN-1:0] : r_shreg[2*XLEN-2:XLEN-1]),
                      r_shreg[XLEN-2:0], w_ge};
    end else begin
      w_shreg_next = {w_sum, r_shreg[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod    = r_neg ? (~r_shreg + (2*XLEN)'(1)) : r_shreg;
    w_dval    = r_op[1] ? r_shreg[2*XLEN-1:XLEN] : r_shreg[XLEN-1:0];
    w_dfix    = r_neg ? (~w_dval + XLEN'(1)) : w_dval;
    if (r_op[2]) begin
      w_fix_res = w_dfix;
    end else if (r_op[1:0] == 2'b00) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_tag    <= '0;
      r_neg    <= 1'b0;
      r_shreg  <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op  <= w_op;
            r_tag <= in_tag;
            r_neg <= w_neg_res;
            r_cnt <= '0;
            if (w_special[XLEN]) begin
              r_result <= w_special[XLEN-1:0];
              r_state  <= ST_DONE;
            end else begin
              r_shreg <= {{XLEN{1'b0}}, w_a_mag};
              r_b     <= w_b_mag;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_shreg <= w_shreg_next;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          r_result <= w_fix_res;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule
